control_unit: RTL and testbench

- Moore/Mealy FSM that sequences the k_and_s `data_path` through fetch, decode and execute for each instruction.
- Drives every datapath control input and the RAM write strobe.
- Consumes `decoded_instruction` and the four ALU flag outputs.
- Sits beside `data_path` inside the processor top level and also keeps a retired-instruction counter for debug and verification.

---
 rtl/control_unit.sv | 184 ++++++++++++++++++
 tb/tb_control_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: fetch/decode/execute sequencer for the k_and_s data_path.
//
// Ports:
//   clk, rst_n               - clock and asynchronous active-low reset
//   decoded_instruction      - current IR decode from data_path
//   zero_op, neg_op,
//   unsigned_overflow,
//   signed_overflow          - ALU flags from data_path
//   branch, pc_enable,
//   ir_enable, addr_sel,
//   c_sel, operation,
//   write_reg_enable,
//   flags_reg_enable         - datapath controls
//   ram_write_enable         - RAM write strobe
//   halt                     - processor halted
//   instr_count              - saturating retired-instruction counter

package k_and_s_pkg;
  typedef enum logic [3:0] {
    I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR,
    I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV, I_HALT
  } decoded_instruction_type;
endpackage

module control_unit
  import k_and_s_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt,
  output logic [CNT_W-1:0]        instr_count
);

  typedef enum logic [3:0] {
    StRst, StFetch, StDecode, StLoad, StStore, StMove, StAlu, StBranch, StHalt
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic             branch_taken;
  logic [1:0]       alu_op;
  logic             cnt_inc;

  // Branch condition; signed_overflow is not consulted by any branch.
  always_comb begin
    branch_taken = 1'b0;
    case (decoded_instruction)
      I_BRANCH: branch_taken = 1'b1;
      I_BZERO:  branch_taken = zero_op;
      I_BNZERO: branch_taken = ~zero_op;
      I_BNEG:   branch_taken = neg_op;
      I_BNNEG:  branch_taken = ~neg_op;
      I_BOV:    branch_taken = unsigned_overflow;
      I_BNOV:   branch_taken = ~unsigned_overflow;
      default:  branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    alu_op = 2'b00;
    case (decoded_instruction)
      I_ADD:   alu_op = 2'b00;
      I_AND:   alu_op = 2'b01;
      I_OR:    alu_op = 2'b10;
      I_SUB:   alu_op = 2'b11;
      default: alu_op = 2'b00;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    operation        = 2'b00;
    write_reg_enable = 1'b0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = 1'b0;
    cnt_inc          = 1'b0;
    case (state_q)
      StRst: state_d = StFetch;
      StFetch: begin
        ir_enable = 1'b1;
        pc_enable = 1'b1;
        state_d   = StDecode;
      end
      StDecode: begin
        case (decoded_instruction)
          I_LOAD:  state_d = StLoad;
          I_STORE: state_d = StStore;
          I_MOVE:  state_d = StMove;
          I_ADD, I_SUB, I_AND, I_OR: state_d = StAlu;
          I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV:
            state_d = StBranch;
          I_HALT: begin
            state_d = StHalt;
            cnt_inc = 1'b1;
          end
          default: begin
            // NOP (and anything unrecognised) retires straight from decode.
            state_d = StFetch;
            cnt_inc = 1'b1;
          end
        endcase
      end
      StLoad: begin
        addr_sel         = 1'b1;
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
        state_d          = StFetch;
        cnt_inc          = 1'b1;
      end
      StStore: begin
        addr_sel         = 1'b1;
        ram_write_enable = 1'b1;
        state_d          = StFetch;
        cnt_inc          = 1'b1;
      end
      StMove: begin
        // MOVE is src OR src, without touching the flags.
        operation        = 2'b10;
        write_reg_enable = 1'b1;
        state_d          = StFetch;
        cnt_inc          = 1'b1;
      end
      StAlu: begin
        operation        = alu_op;
        write_reg_enable = 1'b1;
        flags_reg_enable = 1'b1;
        state_d          = StFetch;
        cnt_inc          = 1'b1;
      end
      StBranch: begin
        // Not taken: PC already advanced past the branch during fetch.
        if (branch_taken) begin
          pc_enable = 1'b1;
          branch    = 1'b1;
          addr_sel  = 1'b1;
        end
        state_d = StFetch;
        cnt_inc = 1'b1;
      end
      StHalt: begin
        halt    = 1'b1;
        state_d = StHalt;
      end
      default: state_d = StRst;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRst;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (cnt_inc && (count_q != {CNT_W{1'b1}})) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign instr_count = count_q;

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;
  import k_and_s_pkg::*;

  localparam int unsigned CNT_W = 4;

  logic clk, rst_n;
  decoded_instruction_type decoded_instruction;
  logic zero_op, neg_op, unsigned_overflow, signed_overflow;
  logic branch, pc_enable, ir_enable, addr_sel, c_sel;
  logic [1:0] operation;
  logic write_reg_enable, flags_reg_enable, ram_write_enable, halt;
  logic [CNT_W-1:0] instr_count;

  control_unit #(.CNT_W(CNT_W)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .decoded_instruction (decoded_instruction),
    .zero_op             (zero_op),
    .neg_op              (neg_op),
    .unsigned_overflow   (unsigned_overflow),
    .signed_overflow     (signed_overflow),
    .branch              (branch),
    .pc_enable           (pc_enable),
    .ir_enable           (ir_enable),
    .addr_sel            (addr_sel),
    .c_sel               (c_sel),
    .operation           (operation),
    .write_reg_enable    (write_reg_enable),
    .flags_reg_enable    (flags_reg_enable),
    .ram_write_enable    (ram_write_enable),
    .halt                (halt),
    .instr_count         (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  // {branch, pc_enable, ir_enable, addr_sel, c_sel, operation, wr, flags, ram_we, halt}
  logic [10:0] outs;
  assign outs = {branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
                 write_reg_enable, flags_reg_enable, ram_write_enable, halt};

  function automatic logic [10:0] mk(logic br, logic pc, logic ir, logic as, logic cs,
                                     logic [1:0] op, logic wr, logic fl, logic rw,
                                     logic h);
    return {br, pc, ir, as, cs, op, wr, fl, rw, h};
  endfunction

  localparam logic [10:0] ZERO = 11'b0;
  localparam logic [10:0] FETCH_EXP = 11'b01100000000;

  typedef struct {
    string                   name;
    decoded_instruction_type instr;
    logic                    z, n, u, s;
    logic [10:0]             exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(string nm, decoded_instruction_type ins, logic z, logic n,
                         logic u, logic s, logic [10:0] e);
    vec_t v;
    v.name = nm; v.instr = ins; v.z = z; v.n = n; v.u = u; v.s = s; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check_outs(string nm, logic [10:0] exp);
    checks++;
    if (outs !== exp) begin
      errors++;
      $display("FAIL %s: outputs got %b expected %b", nm, outs, exp);
    end
  endtask

  task automatic check_cnt(string nm, int exp);
    checks++;
    if (instr_count !== CNT_W'(exp)) begin
      errors++;
      $display("FAIL %s: instr_count got %0d expected %0d", nm, instr_count, exp);
    end
  endtask

  function automatic int sat_inc(int c);
    return (c >= 15) ? 15 : c + 1;
  endfunction

  // Mutual-exclusion monitor over the whole run.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (ir_enable && (write_reg_enable || ram_write_enable)) begin
        errors++;
        $display("FAIL mutex: ir=%b wr=%b ram_we=%b expected no overlap",
                 ir_enable, write_reg_enable, ram_write_enable);
      end
    end
  end

  // Leaves the DUT in FETCH, sampled at a negedge.
  task automatic do_reset();
    rst_n = 1'b0;
    decoded_instruction = I_NOP;
    zero_op = 0; neg_op = 0; unsigned_overflow = 0; signed_overflow = 0;
    @(negedge clk);
    @(negedge clk);
    check_outs("in_reset", ZERO);
    check_cnt("in_reset_cnt", 0);
    rst_n = 1'b1;
    check_outs("rst_state", ZERO);
    @(negedge clk);
    check_outs("first_fetch", FETCH_EXP);
    exp_cnt = 0;
  endtask

  // Expects FETCH at entry; returns at the next FETCH.
  task automatic run_vec(vec_t v);
    check_outs({"fetch_", v.name}, FETCH_EXP);
    decoded_instruction = v.instr;
    zero_op = v.z; neg_op = v.n; unsigned_overflow = v.u; signed_overflow = v.s;
    @(negedge clk);
    check_outs({"decode_", v.name}, ZERO);
    @(negedge clk);
    check_outs({"exec_", v.name}, v.exp);
    @(negedge clk);
    exp_cnt = sat_inc(exp_cnt);
    check_cnt({"cnt_", v.name}, exp_cnt);
  endtask

  initial begin
    logic [10:0] taken, alu_add, halt_exp;
    rst_n = 1'b0;
    decoded_instruction = I_NOP;
    zero_op = 0; neg_op = 0; unsigned_overflow = 0; signed_overflow = 0;

    taken    = mk(1, 1, 0, 1, 0, 2'b00, 0, 0, 0, 0);
    alu_add  = mk(0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 0);
    halt_exp = mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);

    add_vec("add",     I_ADD,    0, 0, 0, 0, alu_add);
    add_vec("load",    I_LOAD,   0, 0, 0, 0, mk(0, 0, 0, 1, 1, 2'b00, 1, 0, 0, 0));
    add_vec("store",   I_STORE,  0, 0, 0, 0, mk(0, 0, 0, 1, 0, 2'b00, 0, 0, 1, 0));
    add_vec("sub",     I_SUB,    0, 0, 0, 0, mk(0, 0, 0, 0, 0, 2'b11, 1, 1, 0, 0));
    add_vec("and",     I_AND,    0, 0, 0, 0, mk(0, 0, 0, 0, 0, 2'b01, 1, 1, 0, 0));
    add_vec("or",      I_OR,     0, 0, 0, 0, mk(0, 0, 0, 0, 0, 2'b10, 1, 1, 0, 0));
    add_vec("move",    I_MOVE,   1, 1, 1, 1, mk(0, 0, 0, 0, 0, 2'b10, 1, 0, 0, 0));
    add_vec("br",      I_BRANCH, 0, 0, 0, 0, taken);
    add_vec("bz_1",    I_BZERO,  1, 0, 0, 0, taken);
    add_vec("bz_0",    I_BZERO,  0, 1, 1, 1, ZERO);
    add_vec("bnz_0",   I_BNZERO, 0, 0, 0, 0, taken);
    add_vec("bnz_1",   I_BNZERO, 1, 0, 0, 0, ZERO);
    add_vec("bneg_1",  I_BNEG,   0, 1, 0, 0, taken);
    add_vec("bneg_0",  I_BNEG,   1, 0, 1, 1, ZERO);
    add_vec("bnneg_0", I_BNNEG,  0, 0, 0, 0, taken);
    add_vec("bnneg_1", I_BNNEG,  0, 1, 0, 0, ZERO);

    do_reset();
    foreach (vecs[i]) run_vec(vecs[i]);

    // Overflow branches in a fresh segment; signed_overflow must be ignored.
    vecs.delete();
    add_vec("bov_1",   I_BOV,    0, 0, 1, 0, taken);
    add_vec("bov_0s",  I_BOV,    1, 1, 0, 1, ZERO);
    add_vec("bnov_0",  I_BNOV,   0, 0, 0, 1, taken);
    add_vec("bnov_1",  I_BNOV,   0, 0, 1, 0, ZERO);
    do_reset();
    foreach (vecs[i]) run_vec(vecs[i]);

    // NOP: two cycles per instruction, counter saturates at 15.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      check_outs("nop_fetch", FETCH_EXP);
      decoded_instruction = I_NOP;
      @(negedge clk);
      check_outs("nop_decode", ZERO);
      @(negedge clk);
      exp_cnt = sat_inc(exp_cnt);
      check_cnt("nop_cnt", exp_cnt);
    end
    check_cnt("nop_saturated", 15);

    // HALT: entered on cycle 3, counted once, sticky until reset.
    do_reset();
    decoded_instruction = I_ADD;
    run_vec('{name: "pre_halt", instr: I_ADD, z: 0, n: 0, u: 0, s: 0, exp: alu_add});
    decoded_instruction = I_HALT;
    @(negedge clk);
    check_outs("halt_decode", ZERO);
    @(negedge clk);
    exp_cnt = sat_inc(exp_cnt);
    decoded_instruction = I_NOP;
    for (int i = 0; i < 100; i++) begin
      check_outs("halt_hold", halt_exp);
      check_cnt("halt_cnt", exp_cnt);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    check_outs("halt_async_rst", ZERO);
    check_cnt("halt_async_rst_cnt", 0);
    @(negedge clk);
    rst_n = 1'b1;
    check_outs("halt_rst_state", ZERO);
    @(negedge clk);
    check_outs("halt_refetch", FETCH_EXP);

    // Reset during ALU aborts the register write.
    decoded_instruction = I_ADD;
    @(negedge clk);
    @(negedge clk);
    check_outs("alu_before_rst", alu_add);
    #2 rst_n = 1'b0;
    #1;
    check_outs("alu_async_rst", ZERO);
    @(posedge clk);
    #1;
    checks++;
    if (write_reg_enable !== 1'b0) begin
      errors++;
      $display("FAIL alu_rst_next: write_reg_enable got %b expected 0", write_reg_enable);
    end
    check_cnt("alu_rst_cnt", 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_outs("alu_rst_refetch", FETCH_EXP);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
